alu_share_ctrl: RTL

Sequencing and arbitration controller for the single 64-bit add/subtract/logic unit in the Y86-64 execute stage. Two requesters share the unit: requester 0 is the execute stage (OPq, condition-code producing), requester 1 is the stack-pointer/address update path (no flag update). The block grants round-robin, latches operands, and runs one operation through the shared combinational core. It returns a registered result and maintains the architectural condition-code register.

---
 rtl/alu_share_pkg.sv | 26 ++
 rtl/alu_core.sv | 64 ++++++
 rtl/alu_share_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_pkg
// Shared definitions for the Y86-64 execute-stage ALU sharing controller:
//   - ALU op-code constants (add, sub, and, xor)
//   - controller FSM state encoding
//   - requester id constants (execute stage, stack-pointer path)
// ---------------------------------------------------------------------------
package alu_share_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Requester 0 owns the architectural condition codes; requester 1 never
  // touches them.
  localparam logic REQ_EXE = 1'b0;
  localparam logic REQ_SP  = 1'b1;

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational add/sub/and/xor unit with flag generation.
// A single adder serves both add and sub: for sub, B is inverted and the
// carry-in is 1, so R = A + ~B + 1 = A - B (mod 2^W).
// Ports:
//   op      in   OPW  operation select (ALU_ADD/SUB/AND/XOR)
//   a, b    in   W    operands
//   result  out  W    operation result
//   borrow  out  1    add: carry-out; sub: borrow (A < B unsigned); else 0
//   zf      out  1    result == 0
//   sf      out  1    result sign bit
//   of      out  1    signed overflow for add/sub; 0 for logic ops
// ---------------------------------------------------------------------------
module alu_core
  import alu_share_pkg::*;
#(
  parameter int W   = 64,
  parameter int OPW = 2
) (
  input  logic [OPW-1:0] op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   result,
  output logic           borrow,
  output logic           zf,
  output logic           sf,
  output logic           of
);

  logic         is_sub;
  logic [W-1:0] b_eff;
  logic [W:0]   sum;

  assign is_sub = (op == ALU_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, is_sub};

  always_comb begin
    result = '0;
    borrow = 1'b0;
    of     = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum[W-1:0];
        borrow = sum[W];
        of     = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        result = sum[W-1:0];
        // Carry-out of A + ~B + 1 is 1 exactly when A >= B, so invert it.
        borrow = ~sum[W];
        of     = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[W-1];

endmodule

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
// Round-robin arbiter and sequencer for the shared execute-stage ALU.
// One operation at a time: IDLE (grant + latch operands) -> EXEC (register
// core outputs) -> RESP (hold response until consumed). The architectural
// condition codes update when a requester-0 response is consumed.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   req_valid[1:0]           per-requester request valid
//   req_ready[1:0]           one-hot grant in IDLE, else 0
//   req_op0/1, req_a0/1, req_b0/1   per-requester op and operands
//   resp_valid / resp_ready  response handshake
//   resp_id                  requester owning the response
//   resp_result, resp_borrow response data
//   cc_zf, cc_sf, cc_of      architectural condition codes
// ---------------------------------------------------------------------------
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int W   = 64,
  parameter int OPW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [OPW-1:0] req_op0,
  input  logic [OPW-1:0] req_op1,
  input  logic [W-1:0]   req_a0,
  input  logic [W-1:0]   req_a1,
  input  logic [W-1:0]   req_b0,
  input  logic [W-1:0]   req_b1,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_id,
  output logic [W-1:0]   resp_result,
  output logic           resp_borrow,
  output logic           cc_zf,
  output logic           cc_sf,
  output logic           cc_of
);

  state_e         state_q, state_d;
  logic           ptr_q, ptr_d;
  logic [OPW-1:0] op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           id_q, id_d;

  logic [W-1:0]   res_q, res_d;
  logic           brw_q, brw_d;
  logic           rid_q, rid_d;
  logic           rzf_q, rzf_d;
  logic           rsf_q, rsf_d;
  logic           rof_q, rof_d;

  logic           czf_q, czf_d;
  logic           csf_q, csf_d;
  logic           cof_q, cof_d;

  // Per-requester inputs gathered into arrays so the grant can index them.
  logic [OPW-1:0] op_in [2];
  logic [W-1:0]   a_in  [2];
  logic [W-1:0]   b_in  [2];

  assign op_in[0] = req_op0;
  assign op_in[1] = req_op1;
  assign a_in[0]  = req_a0;
  assign a_in[1]  = req_a1;
  assign b_in[0]  = req_b0;
  assign b_in[1]  = req_b1;

  // Core outputs
  logic [W-1:0] core_res;
  logic         core_brw, core_zf, core_sf, core_of;

  alu_core #(
    .W   (W),
    .OPW (OPW)
  ) u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (core_res),
    .borrow (core_brw),
    .zf     (core_zf),
    .sf     (core_sf),
    .of     (core_of)
  );

  // Round-robin pick: the pointer's requester wins if valid, else the other.
  logic gnt_valid;
  logic gnt_id;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = ptr_q;
    if (req_valid[ptr_q]) begin
      gnt_valid = 1'b1;
      gnt_id    = ptr_q;
    end else if (req_valid[~ptr_q]) begin
      gnt_valid = 1'b1;
      gnt_id    = ~ptr_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    res_d      = res_q;
    brw_d      = brw_q;
    rid_d      = rid_q;
    rzf_d      = rzf_q;
    rsf_d      = rsf_q;
    rof_d      = rof_q;
    czf_d      = czf_q;
    csf_d      = csf_q;
    cof_d      = cof_q;
    req_ready  = 2'b00;
    resp_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          // req_ready only rises on a valid bit, so a grant is a handshake.
          req_ready[gnt_id] = 1'b1;
          op_d              = op_in[gnt_id];
          a_d               = a_in[gnt_id];
          b_d               = b_in[gnt_id];
          id_d              = gnt_id;
          ptr_d             = ~gnt_id;
          state_d           = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = core_res;
        brw_d   = core_brw;
        rid_d   = id_q;
        rzf_d   = core_zf;
        rsf_d   = core_sf;
        rof_d   = core_of;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = ST_IDLE;
          if (rid_q == REQ_EXE) begin
            czf_d = rzf_q;
            csf_d = rsf_q;
            cof_d = rof_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      rid_q   <= 1'b0;
      rzf_q   <= 1'b0;
      rsf_q   <= 1'b0;
      rof_q   <= 1'b0;
      czf_q   <= 1'b1;
      csf_q   <= 1'b0;
      cof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      rid_q   <= rid_d;
      rzf_q   <= rzf_d;
      rsf_q   <= rsf_d;
      rof_q   <= rof_d;
      czf_q   <= czf_d;
      csf_q   <= csf_d;
      cof_q   <= cof_d;
    end
  end

  assign resp_id     = rid_q;
  assign resp_result = res_q;
  assign resp_borrow = brw_q;
  assign cc_zf       = czf_q;
  assign cc_sf       = csf_q;
  assign cc_of       = cof_q;

endmodule
